// File: rtl/axi_write_master.sv
// AXI3 write master. It takes one burst request, issues AW, streams W beats from a local source
// through a one-entry skid register, collects B, and reports the response with a done pulse.
module axi_write_master #(
    parameter int unsigned buswidth = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic [3:0]          start_len,
    input  logic [2:0]          start_size,
    input  logic [1:0]          start_burst,
    input  logic [1:0]          start_id,
    input  logic [buswidth-1:0] wr_data,
    input  logic                wr_data_valid,
    output logic                wr_data_ready,
    output logic                busy,
    output logic                done,
    output logic [1:0]          resp,
    output logic [1:0]          AWID,
    output logic [31:0]         AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [1:0]          AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [1:0]          WID,
    output logic [buswidth-1:0] WDATA,
    output logic [3:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_awid,    w_awid;
    logic [31:0]         r_awaddr,  w_awaddr;
    logic [LEN_W-1:0]    r_len_q,   w_len_q;
    logic [2:0]          r_awsize,  w_awsize;
    logic [1:0]          r_awburst, w_awburst;
    logic                r_awvalid, w_awvalid;
    logic [buswidth-1:0] r_wdata,   w_wdata;
    logic                r_wvalid,  w_wvalid;
    logic                r_wlast,   w_wlast;
    logic                r_bready,  w_bready;
    logic                r_busy,    w_busy;
    logic                r_done,    w_done;
    logic [1:0]          r_resp,    w_resp;
    logic [CNT_W-1:0]    r_sent_cnt, w_sent_cnt;
    logic [CNT_W-1:0]    r_acc_cnt,  w_acc_cnt;
    logic                w_pop;
    logic                w_accept;
    logic [CNT_W-1:0]    w_len_ext;

    assign w_len_ext = CNT_W'(r_len_q);

    // Source may only pop while the output register is free or draining this cycle.
    assign wr_data_ready = (r_state == S_DATA) && (r_sent_cnt <= w_len_ext)
                           && (!r_wvalid || WREADY);
    assign w_pop    = wr_data_ready && wr_data_valid;
    assign w_accept = r_wvalid && WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_awid      = r_awid;
        w_awaddr    = r_awaddr;
        w_len_q     = r_len_q;
        w_awsize    = r_awsize;
        w_awburst   = r_awburst;
        w_awvalid   = r_awvalid;
        w_wdata     = r_wdata;
        w_wvalid    = r_wvalid;
        w_wlast     = r_wlast;
        w_bready    = r_bready;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_resp      = r_resp;
        w_sent_cnt  = r_sent_cnt;
        w_acc_cnt   = r_acc_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_awid      = start_id;
                    w_awaddr    = start_addr;
                    w_len_q     = start_len;
                    w_awsize    = start_size;
                    w_awburst   = start_burst;
                    w_awvalid   = 1'b1;
                    w_busy      = 1'b1;
                    w_sent_cnt  = '0;
                    w_acc_cnt   = '0;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (AWREADY) begin
                    w_awvalid   = 1'b0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_pop) begin
                    w_wdata    = wr_data;
                    w_wvalid   = 1'b1;
                    w_wlast    = (r_sent_cnt == w_len_ext);
                    w_sent_cnt = r_sent_cnt + CNT_W'(1);
                end else if (w_accept) begin
                    w_wvalid = 1'b0;
                    w_wlast  = 1'b0;
                end
                if (w_accept) begin
                    w_acc_cnt = r_acc_cnt + CNT_W'(1);
                    if (r_acc_cnt == w_len_ext) begin
                        w_bready    = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (BVALID) begin
                    w_resp      = (BID == r_awid) ? BRESP : 2'b10;
                    w_done      = 1'b1;
                    w_busy      = 1'b0;
                    w_bready    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_len_q    <= '0;
            r_awsize   <= '0;
            r_awburst  <= '0;
            r_awvalid  <= 1'b0;
            r_wdata    <= '0;
            r_wvalid   <= 1'b0;
            r_wlast    <= 1'b0;
            r_bready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_resp     <= 2'b00;
            r_sent_cnt <= '0;
            r_acc_cnt  <= '0;
        end else begin
            r_awid     <= w_awid;
            r_awaddr   <= w_awaddr;
            r_len_q    <= w_len_q;
            r_awsize   <= w_awsize;
            r_awburst  <= w_awburst;
            r_awvalid  <= w_awvalid;
            r_wdata    <= w_wdata;
            r_wvalid   <= w_wvalid;
            r_wlast    <= w_wlast;
            r_bready   <= w_bready;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_resp     <= w_resp;
            r_sent_cnt <= w_sent_cnt;
            r_acc_cnt  <= w_acc_cnt;
        end
    end

    assign AWID    = r_awid;
    assign AWADDR  = r_awaddr;
    assign AWLEN   = r_len_q;
    assign AWSIZE  = r_awsize;
    assign AWBURST = r_awburst;
    assign AWLOCK  = 2'b00;
    assign AWCACHE = 4'b0000;
    assign AWPROT  = 3'b000;
    assign AWVALID = r_awvalid;
    assign WID     = r_awid;
    assign WDATA   = r_wdata;
    assign WSTRB   = 4'hF;
    assign WLAST   = r_wlast;
    assign WVALID  = r_wvalid;
    assign BREADY  = r_bready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign resp    = r_resp;

endmodule

// File: tb/tb_axi_write_master.sv
// Self-checking bench for axi_write_master: scoreboarded W beats, AW/W hold rules, B response mapping and reset.
module tb_axi_write_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        start;
    logic [31:0] start_addr;
    logic [3:0]  start_len;
    logic [2:0]  start_size;
    logic [1:0]  start_burst;
    logic [1:0]  start_id;
    logic [31:0] wr_data;
    logic        wr_data_valid;
    logic        wr_data_ready;
    logic        busy;
    logic        done;
    logic [1:0]  resp;
    logic [1:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [1:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] src[0:15];

    always #5 ACLK = ~ACLK;

    axi_write_master #(.buswidth(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .start(start), .start_addr(start_addr), .start_len(start_len),
        .start_size(start_size), .start_burst(start_burst), .start_id(start_id),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .busy(busy), .done(done), .resp(resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic idle_inputs();
        start = 1'b0; start_addr = '0; start_len = '0; start_size = '0;
        start_burst = '0; start_id = '0; wr_data = '0; wr_data_valid = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
    endtask

    // Runs one burst from the posedge+1 phase and scoreboards every W beat; returns to posedge+1.
    task automatic drive_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                               input logic [1:0] id, input logic [31:0] base, input int wmode,
                               input int gap, input int aw_delay, input logic [1:0] bresp,
                               input logic [1:0] bid, input bit restart,
                               output int beats, output int wv_cycles);
        int idx = 0, gap_left = 0, aw_wait = 0;
        bit aw_done = 0, fin = 0, b_prev = 0, restarted = 0, have_prev = 0;
        logic prev_wv = 0, prev_wr = 0, prev_wl = 0, tog = 0;
        logic [31:0] prev_wd = '0, e;
        logic [1:0] exp_resp;
        beats = 0; wv_cycles = 0;
        exp_resp = (bid == id) ? bresp : 2'b10;
        exp_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            src[i] = base + 32'(i);
            exp_q.push_back(base + 32'(i));
        end
        start = 1'b1; start_addr = addr; start_len = len; start_size = 3'd2;
        start_burst = burst; start_id = id;
        @(posedge ACLK); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            AWREADY = (aw_wait >= aw_delay);
            if (wmode == 0) WREADY = 1'b1;
            else if (wmode == 1) begin WREADY = ~tog; tog = ~tog; end
            else WREADY = 1'($urandom_range(0, 1));
            if (gap_left > 0) begin
                wr_data_valid = 1'b0; gap_left--;
            end else begin
                wr_data_valid = (idx <= int'(len));
            end
            wr_data = (idx <= int'(len)) ? src[idx] : 32'h0;
            if (restart && beats == 1 && !restarted) begin
                start = 1'b1; start_addr = 32'hDEAD_0000; start_len = 4'd7;
                start_id = ~id; restarted = 1;
            end
            BVALID = 1'b1; BID = bid; BRESP = bresp;
            @(negedge ACLK);
            checks++;
            if (!aw_done) begin
                if (AWVALID !== 1'b1 || AWADDR !== addr || AWLEN !== len || AWID !== id ||
                    AWBURST !== burst || AWSIZE !== 3'd2 || WVALID !== 1'b0)
                    begin errors++; $display("FAIL aw_hold: AWVALID=%b AWADDR=%h AWLEN=%0d AWID=%0d WVALID=%b, want 1 %h %0d %0d 0",
                                             AWVALID, AWADDR, AWLEN, AWID, WVALID, addr, len, id); end
                aw_wait++;
                if (AWREADY) aw_done = 1;
            end else if (AWVALID !== 1'b0) begin
                errors++; $display("FAIL aw_drop: AWVALID=%b want 0", AWVALID);
            end
            if (have_prev && prev_wv && !prev_wr) begin
                checks++;
                if (WVALID !== 1'b1 || WDATA !== prev_wd || WLAST !== prev_wl)
                    begin errors++; $display("FAIL w_hold: WVALID=%b WDATA=%h WLAST=%b want 1 %h %b",
                                             WVALID, WDATA, WLAST, prev_wd, prev_wl); end
            end
            if (WVALID === 1'b1) wv_cycles++;
            if (WVALID === 1'b1 && WREADY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL w_extra: WDATA=%h with empty scoreboard", WDATA);
                end else begin
                    e = exp_q.pop_front();
                    if (WDATA !== e || WLAST !== (beats == int'(len)) || WID !== id || WSTRB !== 4'hF)
                        begin errors++; $display("FAIL w_beat%0d: WDATA=%h WLAST=%b WID=%0d WSTRB=%h want %h %b %0d F",
                                                 beats, WDATA, WLAST, WID, WSTRB, e, beats == int'(len), id); end
                end
                beats++;
            end
            if (BREADY === 1'b1) begin
                checks++;
                if (beats != int'(len) + 1)
                    begin errors++; $display("FAIL bready_early: beats=%0d want %0d", beats, int'(len) + 1); end
            end
            if (wr_data_ready === 1'b1 && wr_data_valid) begin
                idx++; gap_left = gap;
            end
            checks++;
            if (done === 1'b1) begin
                if (!b_prev || resp !== exp_resp || busy !== 1'b0)
                    begin errors++; $display("FAIL done: b_prev=%b resp=%b busy=%b want 1 %b 0",
                                             b_prev, resp, busy, exp_resp); end
                fin = 1;
            end else if (busy !== 1'b1) begin
                errors++; $display("FAIL busy: busy=%b want 1", busy);
            end
            b_prev  = (BREADY === 1'b1) && BVALID;
            prev_wv = (WVALID === 1'b1); prev_wr = WREADY; prev_wd = WDATA; prev_wl = WLAST;
            have_prev = 1;
            @(posedge ACLK); #1;
            start = 1'b0;
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL timeout: no done, beats=%0d", beats); end
        checks++;
        if (beats != int'(len) + 1 || exp_q.size() != 0)
            begin errors++; $display("FAIL beat_count: beats=%0d left=%0d want %0d 0", beats, exp_q.size(), int'(len) + 1); end
        BVALID = 1'b0; wr_data_valid = 1'b0;
        @(negedge ACLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || BREADY !== 1'b0 || AWVALID !== 1'b0 || resp !== exp_resp)
            begin errors++; $display("FAIL after_done: done=%b busy=%b BREADY=%b AWVALID=%b resp=%b want 0 0 0 0 %b",
                                     done, busy, BREADY, AWVALID, resp, exp_resp); end
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; idle_inputs();
        #12;
        checks++;
        if (AWVALID !== 0 || WVALID !== 0 || WLAST !== 0 || BREADY !== 0 || busy !== 0 || done !== 0 ||
            resp !== 2'b00 || wr_data_ready !== 0 || AWADDR !== 0 || WDATA !== 0 || WSTRB !== 4'hF ||
            AWLOCK !== 0 || AWCACHE !== 0 || AWPROT !== 0)
            begin errors++; $display("FAIL reset: AWVALID=%b WVALID=%b BREADY=%b busy=%b done=%b resp=%b rdy=%b want all 0",
                                     AWVALID, WVALID, BREADY, busy, done, resp, wr_data_ready); end
        @(negedge ACLK); ARESETn = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_single_beat();
        int b, wv;
        drive_burst(32'h100, 4'd0, 2'b01, 2'd1, 32'h5555_0000, 0, 0, 0, 2'b00, 2'd1, 0, b, wv);
    endtask

    task automatic test_wready_toggle();
        int b, wv;
        drive_burst(32'h200, 4'd3, 2'b01, 2'd2, 32'hA0, 1, 0, 0, 2'b00, 2'd2, 0, b, wv);
    endtask

    task automatic test_aw_stall();
        int b, wv;
        drive_burst(32'h3000, 4'd1, 2'b10, 2'd3, 32'hC0, 0, 0, 5, 2'b01, 2'd3, 0, b, wv);
    endtask

    task automatic test_data_gaps();
        int b, wv;
        drive_burst(32'h400, 4'd2, 2'b01, 2'd0, 32'hD0, 0, 3, 0, 2'b00, 2'd0, 0, b, wv);
        checks++;
        if (wv != 3) begin errors++; $display("FAIL gap_wvalid: WVALID-high cycles=%0d want 3", wv); end
    endtask

    task automatic test_start_busy_bid();
        int b, wv;
        drive_burst(32'h500, 4'd3, 2'b01, 2'd1, 32'hE0, 0, 0, 0, 2'b00, 2'd2, 1, b, wv);
        drive_burst(32'h600, 4'd1, 2'b00, 2'd2, 32'hF0, 0, 0, 0, 2'b10, 2'd2, 0, b, wv);
    endtask

    task automatic test_len15();
        int b, wv;
        drive_burst(32'h1000, 4'd15, 2'b01, 2'd3, 32'h1000, 2, 0, 1, 2'b00, 2'd3, 0, b, wv);
    endtask

    task automatic test_reset_mid_burst();
        int b, wv;
        int beats = 0;
        start = 1'b1; start_addr = 32'h700; start_len = 4'd3; start_burst = 2'b01; start_id = 2'd1;
        @(posedge ACLK); #1;
        start = 1'b0; AWREADY = 1'b1; WREADY = 1'b1; wr_data_valid = 1'b1; wr_data = 32'h77;
        for (int cyc = 0; cyc < 50 && beats < 2; cyc++) begin
            @(negedge ACLK);
            if (WVALID === 1'b1 && WREADY) beats++;
            @(posedge ACLK); #1;
        end
        checks++;
        if (beats != 2) begin errors++; $display("FAIL mid_setup: beats=%0d want 2", beats); end
        #2 ARESETn = 1'b0;
        #1;
        checks++;
        if (AWVALID !== 0 || WVALID !== 0 || BREADY !== 0 || busy !== 0 || wr_data_ready !== 0 || resp !== 2'b00)
            begin errors++; $display("FAIL mid_reset: AWVALID=%b WVALID=%b BREADY=%b busy=%b rdy=%b resp=%b want 0",
                                     AWVALID, WVALID, BREADY, busy, wr_data_ready, resp); end
        idle_inputs();
        @(negedge ACLK); ARESETn = 1'b1;
        @(posedge ACLK); #1;
        drive_burst(32'h800, 4'd3, 2'b01, 2'd0, 32'hB0, 0, 0, 0, 2'b00, 2'd0, 0, b, wv);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_wready_toggle();
        test_aw_stall();
        test_data_gaps();
        test_start_busy_bid();
        test_len15();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
